spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_if.sv | 42 ++++
 rtl/spi_clk_div.sv | 37 +++
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants, state encoding and sizing helper
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // Divider counter width: $clog2(div), but never narrower than one bit.
    function automatic int div_cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - local handshake plus SPI pins of the SPI master
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sclk;
    logic             mosi;
    logic             ce0;
    logic             miso;

    modport master (
        input  start,
        input  tx_data,
        input  miso,
        output busy,
        output done,
        output rx_data,
        output sclk,
        output mosi,
        output ce0
    );

    modport slave (
        output start,
        output tx_data,
        output miso,
        input  busy,
        input  done,
        input  rx_data,
        input  sclk,
        input  mosi,
        input  ce0
    );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator for the SPI serial clock
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic rstn,
    input  logic clear_i,
    output logic tick_o
);

    localparam int            CW   = div_cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Wrapping on the tick makes every phase after the clear exactly CLK_DIV cycles.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, MSB first, one word per chip-select frame
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = SPI_WIDTH
) (
    input logic          clock,
    input logic          rstn,
    spi_master_if.master bus
);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_master: CLK_DIV must be >= 1");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("spi_master: WIDTH must be >= 2");
    end

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

    spi_state_e       state_q,    state_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic             sclk_q,     sclk_d;
    logic             mosi_q,     mosi_d;
    logic             ce0_q,      ce0_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic div_tick;
    logic div_clear;
    logic sample;

    assign div_clear = (state_q == IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clock   (clock),
        .rstn    (rstn),
        .clear_i (div_clear),
        .tick_o  (div_tick)
    );

    // Rising sclk edges: end of SETUP, and end of every LOW phase except the CS hold.
    assign sample = div_tick &&
                    ((state_q == SETUP) || ((state_q == LOW) && (bit_cnt_q != LAST_BIT)));

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ce0_d      = ce0_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (sample) begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[WIDTH-2:0], bus.miso};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            state_d    = HIGH;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_shift_d = bus.tx_data;
                    mosi_d     = bus.tx_data[WIDTH-1];
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    ce0_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end
            HIGH: begin
                if (div_tick) begin
                    sclk_d     = 1'b0;
                    tx_shift_d = tx_shift_q << 1;
                    mosi_d     = tx_shift_d[WIDTH-1];
                    state_d    = LOW;
                end
            end
            LOW: begin
                if (div_tick && (bit_cnt_q == LAST_BIT)) begin
                    ce0_d     = 1'b1;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                // Guarantees a ce0 high pulse so the slave latches its word.
                if (div_tick) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            ce0_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ce0_q      <= ce0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.ce0     = ce0_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;
    import spi_pkg::*;

    logic       clock = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       use_slave = 1'b0;
    logic [7:0] tx_data = 8'h00;

    always #5 clock = ~clock;

    spi_master_if #(.WIDTH(8)) b2 ();
    spi_master_if #(.WIDTH(8)) b1 ();

    assign b2.start   = start & ~sel;
    assign b1.start   = start & sel;
    assign b2.tx_data = tx_data;
    assign b1.tx_data = tx_data;

    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;

    assign b2.miso = use_slave ? s_tx[7] : b2.mosi;
    assign b1.miso = b1.mosi;

    spi_master #(.CLK_DIV(2), .WIDTH(8)) dut2 (.clock(clock), .rstn(rstn), .bus(b2));
    spi_master #(.CLK_DIV(1), .WIDTH(8)) dut1 (.clock(clock), .rstn(rstn), .bus(b1));

    // Mode-0 slave: load on ce0 fall, sample on sclk rise, shift out on sclk fall.
    always @(negedge b2.ce0) s_tx = 8'h3C;
    always @(posedge b2.sclk) if (b2.ce0 === 1'b0) s_rx = {s_rx[6:0], b2.mosi};
    always @(negedge b2.sclk) if (b2.ce0 === 1'b0) s_tx = s_tx << 1;

    logic       m_ce0, m_sclk, m_mosi, m_busy, m_done;
    logic [7:0] m_rx;
    assign m_ce0  = sel ? b1.ce0     : b2.ce0;
    assign m_sclk = sel ? b1.sclk    : b2.sclk;
    assign m_mosi = sel ? b1.mosi    : b2.mosi;
    assign m_busy = sel ? b1.busy    : b2.busy;
    assign m_done = sel ? b1.done    : b2.done;
    assign m_rx   = sel ? b1.rx_data : b2.rx_data;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Timing monitor: mosi vs sclk-rise spacing, and sclk low at every ce0 change.
    int   cyc = 0;
    int   last_rise = -1000;
    int   last_mchg = -1000;
    int   viol = 0;
    logic p_ce0 = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    logic rst_at_edge = 1'b1;

    always @(posedge clock) rst_at_edge = !rstn;

    always @(negedge clock) begin
        int div;
        div = sel ? 1 : 2;
        cyc++;
        if (!rst_at_edge) begin
            if (m_ce0 !== p_ce0 && (m_sclk !== 1'b0 || p_sclk !== 1'b0)) viol++;
            if (m_ce0 === 1'b0 && p_ce0 === 1'b0) begin
                if (m_sclk && !p_sclk && (cyc - last_mchg) < div) viol++;
                if (m_mosi !== p_mosi && (cyc - last_rise) < div) viol++;
            end
        end
        if (m_sclk && !p_sclk) last_rise = cyc;
        if (m_mosi !== p_mosi) last_mchg = cyc;
        p_ce0  = m_ce0;
        p_sclk = m_sclk;
        p_mosi = m_mosi;
    end

    task automatic run_frame(input string tag, input logic [7:0] tx, input logic [7:0] exp_rx,
                             input int exp_low, input int poke);
        int   n = 0, low = 0, rises = 0, dones = 0, done_at = -1;
        logic ps;
        logic fin = 1'b0;
        @(negedge clock);
        start   = 1'b1;
        tx_data = tx;
        ps      = m_sclk;
        while (!fin && n < 300) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check({tag, ".busy_after_accept"}, m_busy, 1);
            end
            if (poke != 0 && n == poke) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end
            if (poke != 0 && n == poke + 1) start = 1'b0;
            if (m_ce0 === 1'b0) low++;
            if (m_sclk && !ps) rises++;
            ps = m_sclk;
            if (m_done === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && m_busy === 1'b0) fin = 1'b1;
        end
        check({tag, ".finished"}, fin, 1);
        check({tag, ".ce0_low_cycles"}, low, exp_low);
        check({tag, ".sclk_rises"}, rises, 8);
        check({tag, ".done_latency"}, done_at, exp_low + 1);
        check({tag, ".done_pulses"}, dones, 1);
        check({tag, ".rx_data"}, m_rx, exp_rx);
    endtask

    initial begin
        int n, rises, dones, gap, d2;
        logic ps, in_gap;
        logic [7:0] rx1, rx2;

        repeat (3) @(negedge clock);
        check("reset.ce0", b2.ce0, 1);
        check("reset.sclk", b2.sclk, 0);
        check("reset.mosi", b2.mosi, 0);
        check("reset.busy", b2.busy, 0);
        check("reset.done", b2.done, 0);
        check("reset.rx_data", b2.rx_data, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clock);

        run_frame("loop_a5", 8'hA5, 8'hA5, 34, 0);

        use_slave = 1'b1;
        run_frame("slave_c3", 8'hC3, 8'h3C, 34, 0);
        check("slave_c3.slave_rx", s_rx, 8'hC3);
        use_slave = 1'b0;

        run_frame("poke_ff", 8'h69, 8'h69, 34, 9);

        // Abort after the 4th rising sclk.
        @(negedge clock);
        start   = 1'b1;
        tx_data = 8'h33;
        ps      = m_sclk;
        rises   = 0;
        n       = 0;
        while (rises < 4 && n < 100) begin
            @(negedge clock);
            n++;
            start = 1'b0;
            if (m_sclk && !ps) rises++;
            ps = m_sclk;
        end
        check("abort.reached_4_rises", rises, 4);
        rstn = 1'b0;
        @(negedge clock);
        rstn = 1'b1;
        check("abort.ce0", m_ce0, 1);
        check("abort.sclk", m_sclk, 0);
        check("abort.busy", m_busy, 0);
        check("abort.rx_data", m_rx, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (m_done !== 1'b0) dones++;
        end
        check("abort.no_done", dones, 0);
        run_frame("after_abort_5a", 8'h5A, 8'h5A, 34, 0);

        // start held high: two back-to-back frames.
        @(negedge clock);
        start   = 1'b1;
        tx_data = 8'h01;
        n = 0; dones = 0; gap = 0; d2 = 0; in_gap = 1'b0;
        rx1 = 8'h00; rx2 = 8'h00;
        while (d2 == 0 && n < 300) begin
            @(negedge clock);
            n++;
            if (n == 1) tx_data = 8'h80;
            if (m_done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    rx1    = m_rx;
                    in_gap = 1'b1;
                end else begin
                    rx2 = m_rx;
                    d2  = n;
                end
            end
            if (in_gap) begin
                if (m_ce0 === 1'b1) gap++;
                else begin
                    in_gap = 1'b0;
                    start  = 1'b0;
                end
            end
        end
        repeat (6) @(negedge clock);
        check("b2b.done_count", dones, 2);
        check("b2b.rx_first", rx1, 8'h01);
        check("b2b.rx_second", rx2, 8'h80);
        check("b2b.ce0_gap_cycles", gap, 3);
        check("b2b.second_done_at", d2, 35 + 37);
        check("b2b.idle_after", m_busy, 0);

        sel = 1'b1;
        run_frame("div1_96", 8'h96, 8'h96, 17, 0);
        sel = 1'b0;

        check("timing.mosi_sclk_spacing", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
